// File: rtl/ula_mul8.sv
// rtl/ula_mul8.sv - iterative 8x8 shift-add multiplier sharing the ULA ripple adder
// Optional MUL_NZ_EN: registered negative/zero flags of the product.
module ula_mul8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    input  logic [7:0]  add_s,
    input  logic        add_co,
    output logic        busy,
    output logic        done,
    output logic [15:0] prod,
    output logic        n_flag,
    output logic        z_flag
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  m_q, m_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] prod_q, prod_d;
    logic [15:0] step;
    logic        last_iter;

    // The adder carry becomes the new hi MSB; lo[0] falls off the right end.
    assign step      = {add_co, add_s, lo_q[7:1]};
    assign last_iter = (state_q == ST_RUN) && (cnt_q == 3'd7);

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = op_a;
                    hi_d    = 8'h00;
                    lo_d    = op_b;
                    cnt_d   = 3'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                {hi_d, lo_d} = step;
                cnt_d        = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    prod_d  = step;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m_q     <= 8'h00;
            hi_q    <= 8'h00;
            lo_q    <= 8'h00;
            cnt_q   <= 3'd0;
            prod_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign add_a = (state_q == ST_RUN) ? hi_q : 8'h00;
    assign add_b = ((state_q == ST_RUN) && lo_q[0]) ? m_q : 8'h00;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign prod  = prod_q;

`ifdef MUL_NZ_EN
    logic n_q, z_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
        end else if (last_iter) begin
            n_q <= step[15];
            z_q <= (step == 16'h0000);
        end
    end

    assign n_flag = n_q;
    assign z_flag = z_q;
`else
    assign n_flag = 1'b0;
    assign z_flag = 1'b0;
`endif

endmodule
